writeback_stage: RTL and testbench

Final stage of the 8-bit pipelined core; sits directly downstream of the Execution stage.
- Consumes the Execution stage's result, carry, operation and data fields.
- Commits results into the architectural A/B registers and their carry flags.
- Performs LDA/LDB/STA/STB through a req/ack data-memory port, stalling upstream stages while a memory access is outstanding.
- Drives the A/B register values and carries back to Execution as its operands.

---
 rtl/cpu_defs.sv | 55 +++++
 rtl/wb_mem_port.sv | 99 +++++++++
 rtl/writeback_stage.sv | 120 ++++++++++++
 tb/tb_writeback_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared definitions for the 8-bit pipelined core: opcodes, op classes, FSM states.
// Decode treats every code not listed here as a NOP.
package cpu_defs;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 10;
  localparam int OP_W   = 6;

  localparam logic [OP_W-1:0] OP_NOP   = 6'h00;
  localparam logic [OP_W-1:0] OP_ANDA  = 6'h01;
  localparam logic [OP_W-1:0] OP_ORA   = 6'h02;
  localparam logic [OP_W-1:0] OP_ASRA  = 6'h03;
  localparam logic [OP_W-1:0] OP_ADDA  = 6'h04;
  localparam logic [OP_W-1:0] OP_SUBA  = 6'h05;
  localparam logic [OP_W-1:0] OP_ANDCB = 6'h09;
  localparam logic [OP_W-1:0] OP_ORCB  = 6'h0A;
  localparam logic [OP_W-1:0] OP_ASRB  = 6'h0B;
  localparam logic [OP_W-1:0] OP_ADDB  = 6'h0C;
  localparam logic [OP_W-1:0] OP_SUBB  = 6'h0D;
  localparam logic [OP_W-1:0] OP_LDA   = 6'h10;
  localparam logic [OP_W-1:0] OP_LDB   = 6'h11;
  localparam logic [OP_W-1:0] OP_STA   = 6'h12;
  localparam logic [OP_W-1:0] OP_STB   = 6'h13;

  typedef enum logic [2:0] {
    CL_NOP,
    CL_ALU_A,
    CL_ALU_B,
    CL_LOAD,
    CL_STORE
  } op_class_t;

  typedef enum logic {
    ST_IDLE,
    ST_MEM_WAIT
  } wb_state_t;

  function automatic op_class_t decodeOp(input logic [OP_W-1:0] op);
    op_class_t cls;
    case (op)
      OP_ANDA, OP_ORA, OP_ASRA, OP_ADDA, OP_SUBA:   cls = CL_ALU_A;
      OP_ANDCB, OP_ORCB, OP_ASRB, OP_ADDB, OP_SUBB: cls = CL_ALU_B;
      OP_LDA, OP_LDB:                               cls = CL_LOAD;
      OP_STA, OP_STB:                               cls = CL_STORE;
      default:                                      cls = CL_NOP;
    endcase
    return cls;
  endfunction

  // Memory ops name their register in the opcode; B variants select register B.
  function automatic logic opUsesB(input logic [OP_W-1:0] op);
    return (op == OP_LDB) || (op == OP_STB);
  endfunction

endpackage

// File: rtl/wb_mem_port.sv
// Data-memory port of the writeback stage: IDLE/MEM_WAIT FSM, timeout counter,
// request latches, upstream stall and sticky timeout error.
module wb_mem_port
  import cpu_defs::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  op_class_t         i_opClass,
  input  logic              i_useB,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_regA,
  input  logic [DATA_W-1:0] i_regB,
  input  logic              i_memAck,
  output logic              o_memReq,
  output logic              o_memWe,
  output logic [ADDR_W-1:0] o_memAddr,
  output logic [DATA_W-1:0] o_memWData,
  output logic              o_memErr,
  output logic              o_stall,
  output logic              o_idle,
  output logic              o_loadAck,
  output logic              o_destB
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  wb_state_t         r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_memReq;
  logic              r_memWe;
  logic [ADDR_W-1:0] r_memAddr;
  logic [DATA_W-1:0] r_memWData;
  logic              r_memErr;
  logic              r_destB;

  logic w_idle;
  logic w_memOp;
  logic w_timeout;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_memOp   = (i_opClass == CL_LOAD) || (i_opClass == CL_STORE);
  // Ack in the final wait cycle still wins over the abort.
  assign w_timeout = !w_idle && !i_memAck && (r_cnt == CNT_W'(MEM_TIMEOUT - 1));

  assign o_stall    = w_idle ? w_memOp : (!i_memAck && !w_timeout);
  assign o_idle     = w_idle;
  assign o_loadAck  = !w_idle && i_memAck && !r_memWe;
  assign o_destB    = r_destB;
  assign o_memReq   = r_memReq;
  assign o_memWe    = r_memWe;
  assign o_memAddr  = r_memAddr;
  assign o_memWData = r_memWData;
  assign o_memErr   = r_memErr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_memReq   <= 1'b0;
      r_memWe    <= 1'b0;
      r_memAddr  <= '0;
      r_memWData <= '0;
      r_memErr   <= 1'b0;
      r_destB    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_memOp) begin
            r_memAddr  <= i_addr;
            r_memWe    <= (i_opClass == CL_STORE);
            r_memWData <= i_useB ? i_regB : i_regA;
            r_destB    <= i_useB;
            r_memReq   <= 1'b1;
            r_cnt      <= '0;
            r_state    <= ST_MEM_WAIT;
          end
        end
        ST_MEM_WAIT: begin
          if (i_memAck) begin
            r_memReq <= 1'b0;
            r_state  <= ST_IDLE;
          end else if (w_timeout) begin
            r_memReq <= 1'b0;
            r_memErr <= 1'b1;
            r_state  <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: A/B register file with carries, ALU and load commit, memory port.
// Optional macro WB_BYPASS_EN forwards next-state register values combinationally.
module writeback_stage
  import cpu_defs::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OP_W-1:0]   iOperation_EXC,
  input  logic [ADDR_W-1:0] iData_EXC,
  input  logic [DATA_W-1:0] iResult,
  input  logic              iCarry,
  output logic [DATA_W-1:0] oReg_A,
  output logic              oCarryA,
  output logic [DATA_W-1:0] oReg_B,
  output logic              oCarryB,
  output logic              oStall,
  output logic              oMemReq,
  output logic              oMemWe,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [DATA_W-1:0] oMemWData,
  input  logic              iMemAck,
  input  logic [DATA_W-1:0] iMemRData,
  output logic              oMemErr
);

  logic [DATA_W-1:0] r_regA;
  logic [DATA_W-1:0] r_regB;
  logic              r_carryA;
  logic              r_carryB;

  op_class_t         w_opClass;
  logic              w_useB;
  logic              w_idle;
  logic              w_loadAck;
  logic              w_destB;
  logic [DATA_W-1:0] w_nextA;
  logic [DATA_W-1:0] w_nextB;
  logic              w_nextCarryA;
  logic              w_nextCarryB;

  assign w_opClass = decodeOp(iOperation_EXC);
  assign w_useB    = opUsesB(iOperation_EXC);

  wb_mem_port #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_memPort (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_opClass  (w_opClass),
    .i_useB     (w_useB),
    .i_addr     (iData_EXC),
    .i_regA     (r_regA),
    .i_regB     (r_regB),
    .i_memAck   (iMemAck),
    .o_memReq   (oMemReq),
    .o_memWe    (oMemWe),
    .o_memAddr  (oMemAddr),
    .o_memWData (oMemWData),
    .o_memErr   (oMemErr),
    .o_stall    (oStall),
    .o_idle     (w_idle),
    .o_loadAck  (w_loadAck),
    .o_destB    (w_destB)
  );

  // ALU ops only commit from IDLE; loads commit data but never touch the carry.
  always_comb begin
    w_nextA      = r_regA;
    w_nextB      = r_regB;
    w_nextCarryA = r_carryA;
    w_nextCarryB = r_carryB;
    if (w_idle && (w_opClass == CL_ALU_A)) begin
      w_nextA      = iResult;
      w_nextCarryA = iCarry;
    end
    if (w_idle && (w_opClass == CL_ALU_B)) begin
      w_nextB      = iResult;
      w_nextCarryB = iCarry;
    end
    if (w_loadAck && !w_destB) begin
      w_nextA = iMemRData;
    end
    if (w_loadAck && w_destB) begin
      w_nextB = iMemRData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regA   <= '0;
      r_regB   <= '0;
      r_carryA <= 1'b0;
      r_carryB <= 1'b0;
    end else begin
      r_regA   <= w_nextA;
      r_regB   <= w_nextB;
      r_carryA <= w_nextCarryA;
      r_carryB <= w_nextCarryB;
    end
  end

`ifdef WB_BYPASS_EN
  assign oReg_A  = w_nextA;
  assign oCarryA = w_nextCarryA;
  assign oReg_B  = w_nextB;
  assign oCarryB = w_nextCarryB;
`else
  assign oReg_A  = r_regA;
  assign oCarryA = r_carryA;
  assign oReg_B  = r_regB;
  assign oCarryB = r_carryB;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios then random ops
// against a transaction-level model of the A/B registers and memory port.
module tb_writeback_stage;
  import cpu_defs::*;

  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] iOperation_EXC;
  logic [9:0] iData_EXC;
  logic [7:0] iResult;
  logic       iCarry;
  logic [7:0] oReg_A;
  logic       oCarryA;
  logic [7:0] oReg_B;
  logic       oCarryB;
  logic       oStall;
  logic       oMemReq;
  logic       oMemWe;
  logic [9:0] oMemAddr;
  logic [7:0] oMemWData;
  logic       iMemAck;
  logic [7:0] iMemRData;
  logic       oMemErr;

  writeback_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .iOperation_EXC (iOperation_EXC),
    .iData_EXC      (iData_EXC),
    .iResult        (iResult),
    .iCarry         (iCarry),
    .oReg_A         (oReg_A),
    .oCarryA        (oCarryA),
    .oReg_B         (oReg_B),
    .oCarryB        (oCarryB),
    .oStall         (oStall),
    .oMemReq        (oMemReq),
    .oMemWe         (oMemWe),
    .oMemAddr       (oMemAddr),
    .oMemWData      (oMemWData),
    .iMemAck        (iMemAck),
    .iMemRData      (iMemRData),
    .oMemErr        (oMemErr)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int errorCount = 0;

  logic [7:0] mA, mB;
  logic       mCA, mCB, mErr;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // 0 nop, 1 alu A, 2 alu B, 3 LDA, 4 LDB, 5 STA, 6 STB
  function automatic int opKind(input logic [5:0] op);
    if (op inside {OP_ANDA, OP_ORA, OP_ASRA, OP_ADDA, OP_SUBA}) return 1;
    if (op inside {OP_ANDCB, OP_ORCB, OP_ASRB, OP_ADDB, OP_SUBB}) return 2;
    if (op == OP_LDA) return 3;
    if (op == OP_LDB) return 4;
    if (op == OP_STA) return 5;
    if (op == OP_STB) return 6;
    return 0;
  endfunction

  task automatic checkRegs(input string where);
    checkOutput({where, " regA"}, oReg_A, mA);
    checkOutput({where, " carryA"}, oCarryA, mCA);
    checkOutput({where, " regB"}, oReg_B, mB);
    checkOutput({where, " carryB"}, oCarryB, mCB);
    checkOutput({where, " memErr"}, oMemErr, mErr);
  endtask

  task automatic modelReset();
    mA = 8'h00; mB = 8'h00; mCA = 1'b0; mCB = 1'b0; mErr = 1'b0;
  endtask

  task automatic applyReset(input int cycles);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkRegs("reset");
    checkOutput("reset memReq", oMemReq, 0);
    checkOutput("reset memWe", oMemWe, 0);
    checkOutput("reset memAddr", oMemAddr, 0);
    checkOutput("reset memWData", oMemWData, 0);
    checkOutput("reset stall", oStall, 0);
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Called one time unit after a rising edge; returns at the same phase.
  // ackCycle: MEM_WAIT cycle (1..TIMEOUT) with ack, 0 = never ack.
  task automatic applyStimulus(input logic [5:0] op, input logic [9:0] data, input logic [7:0] res,
                               input logic carry, input int ackCycle, input logic [7:0] rdata);
    int kind;
    bit done;
    bit isStore, useB;
    logic [7:0] expWData;
    kind = opKind(op);
    iOperation_EXC = op;
    iData_EXC      = data;
    iResult        = res;
    iCarry         = carry;
    iMemRData      = rdata;
    iMemAck        = 1'($urandom_range(0, 1));
    #1;
    if (kind <= 2) begin
      checkOutput("alu stall", oStall, 0);
      checkOutput("alu memReq", oMemReq, 0);
`ifdef WB_BYPASS_EN
      if (kind == 1) begin
        checkOutput("bypass regA", oReg_A, res);
        checkOutput("bypass carryA", oCarryA, carry);
      end else if (kind == 2) begin
        checkOutput("bypass regB", oReg_B, res);
        checkOutput("bypass carryB", oCarryB, carry);
      end
`else
      if (kind == 1) checkOutput("latency regA", oReg_A, mA);
      if (kind == 2) checkOutput("latency regB", oReg_B, mB);
`endif
      @(posedge clk);
      #1;
      if (kind == 1) begin mA = res; mCA = carry; end
      if (kind == 2) begin mB = res; mCB = carry; end
      iMemAck = 1'b0;
      checkRegs("alu");
    end else begin
      isStore  = (kind >= 5);
      useB     = (kind == 4) || (kind == 6);
      expWData = useB ? mB : mA;
      checkOutput("mem idle stall", oStall, 1);
      checkOutput("mem idle memReq", oMemReq, 0);
      @(posedge clk);
      #1;
      done = 1'b0;
      for (int k = 1; k <= TIMEOUT; k++) begin
        iMemAck = (k == ackCycle);
        #1;
        checkOutput("wait memReq", oMemReq, 1);
        checkOutput("wait memWe", oMemWe, isStore);
        checkOutput("wait memAddr", oMemAddr, data);
        if (isStore) checkOutput("wait memWData", oMemWData, expWData);
        checkOutput("wait stall", oStall, (k == ackCycle || k == TIMEOUT) ? 0 : 1);
`ifdef WB_BYPASS_EN
        if (k == ackCycle && kind == 3) checkOutput("bypass load A", oReg_A, rdata);
        if (k == ackCycle && kind == 4) checkOutput("bypass load B", oReg_B, rdata);
`endif
        @(posedge clk);
        #1;
        if (k == ackCycle) begin
          done = 1'b1;
          if (kind == 3) mA = rdata;
          if (kind == 4) mB = rdata;
          break;
        end
      end
      if (!done) mErr = 1'b1;
      iMemAck        = 1'b0;
      iOperation_EXC = OP_NOP;
      checkOutput("after memReq", oMemReq, 0);
      checkRegs("mem");
    end
    if (kind == 0) begin
      checkOutput("nop stall", oStall, 0);
      iMemAck = 1'b0;
      @(posedge clk);
      #1;
      checkRegs("nop");
    end
  endtask

  logic [5:0] opPool [0:17];

  initial begin
    opPool = '{OP_NOP, OP_ANDA, OP_ORA, OP_ASRA, OP_ADDA, OP_SUBA, OP_ANDCB, OP_ORCB, OP_ASRB,
               OP_ADDB, OP_SUBB, OP_LDA, OP_LDB, OP_STA, OP_STB, 6'h3F, 6'h21, 6'h17};
    rst_n = 1'b0;
    iOperation_EXC = OP_NOP; iData_EXC = '0; iResult = '0; iCarry = 1'b0;
    iMemAck = 1'b0; iMemRData = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Plan 1: activity, mid-stream reset, then ANDA
    applyStimulus(OP_ORA, 10'd0, 8'h77, 1'b1, 0, 8'h00);
    applyStimulus(OP_ORCB, 10'd0, 8'h12, 1'b1, 0, 8'h00);
    applyReset(2);
    applyStimulus(OP_ANDA, 10'd0, 8'h00, 1'b1, 0, 8'h00);
    checkOutput("plan1 carryA", oCarryA, 1);

    // Plan 2
    applyStimulus(OP_ORCB, 10'd0, 8'h55, 1'b0, 0, 8'h00);
    applyStimulus(OP_ASRA, 10'd0, 8'hD5, 1'b0, 0, 8'h00);

    // Plan 3: STA with ack on the third wait cycle
    applyStimulus(OP_ORA, 10'd0, 8'hAA, 1'b0, 0, 8'h00);
    applyStimulus(OP_STA, 10'd76, 8'h00, 1'b0, 3, 8'h00);

    // Plan 4: LDB acked immediately, carry kept
    applyStimulus(OP_LDB, 10'd300, 8'h00, 1'b0, 1, 8'h3C);

    // Plan 5: LDA timeout, sticky error
    applyStimulus(OP_LDA, 10'd5, 8'h00, 1'b0, 0, 8'hEE);
    applyStimulus(OP_ANDCB, 10'd0, 8'h0F, 1'b1, 0, 8'h00);
    applyStimulus(OP_STB, 10'd9, 8'h00, 1'b0, 2, 8'h00);

    // Plan 6: reset during MEM_WAIT, late ack ignored
    iOperation_EXC = OP_STA; iData_EXC = 10'd44; iMemAck = 1'b0;
    @(posedge clk);
    #1;
    iOperation_EXC = OP_NOP;
    checkOutput("plan6 memReq before reset", oMemReq, 1);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("plan6 async memReq", oMemReq, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    iMemAck = 1'b1; iMemRData = 8'h99;
    @(posedge clk);
    #1;
    iMemAck = 1'b0;
    checkOutput("plan6 memReq", oMemReq, 0);
    checkRegs("plan6");

    // Random phase
    for (int n = 0; n < 200; n++) begin
      int r;
      r = $urandom_range(0, 19);
      applyStimulus(opPool[$urandom_range(0, 17)], 10'($urandom), 8'($urandom), 1'($urandom),
                    (r > TIMEOUT) ? 0 : r, 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
